// File: rtl/sd_hc_spi_responder.sv
// sd_hc_spi_responder: SPI-mode SDHC card emulator answering CMD0/8/17/55/58 and ACMD41 with deterministic read data.
module sd_hc_spi_responder #(
  parameter int BLOCK_SIZE   = 512,
  parameter int NCR_BYTES    = 1,
  parameter int NAC_BYTES    = 2,
  parameter int ACMD41_COUNT = 2
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_csn,
  input  logic i_sck,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_ready,
  output logic o_busy
);
  localparam logic [15:0] NCR  = 16'(NCR_BYTES);
  localparam logic [15:0] NAC  = 16'(NAC_BYTES);
  localparam logic [15:0] BLK  = 16'(BLOCK_SIZE);
  localparam logic [7:0]  ACNT = 8'(ACMD41_COUNT);

  logic [1:0]  r_csn_s, r_sck_s, r_mosi_s;
  logic        r_sck_d;
  logic [2:0]  r_bit;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic [2:0]  r_fcnt;
  logic [5:0]  r_cmd;
  logic [7:0]  r_arg;
  logic        r_busy, r_data, r_idle, r_app;
  logic [7:0]  r_acnt;
  logic [39:0] r_resp;
  logic [15:0] r_pos, r_total;
  logic [7:0]  r_dbyte;
  logic [15:0] r_crc;

  logic        w_csn, w_rise, w_fall, w_boundary, w_load, w_pre, w_is_data;
  logic [7:0]  w_byte, w_next;
  logic [15:0] w_dpos;
  logic [39:0] w_resp;
  logic [15:0] w_len;
  logic        w_rdata, w_idle_n, w_app_n;
  logic [7:0]  w_acnt_n;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      r_csn_s  <= 2'b11;
      r_sck_s  <= 2'b00;
      r_mosi_s <= 2'b00;
      r_sck_d  <= 1'b0;
    end else begin
      r_csn_s  <= {r_csn_s[0], i_csn};
      r_sck_s  <= {r_sck_s[0], i_sck};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_sck_d  <= r_sck_s[1];
    end

  assign w_csn      = r_csn_s[1];
  assign w_rise     = r_sck_s[1] & ~r_sck_d;
  assign w_fall     = ~r_sck_s[1] & r_sck_d;
  assign w_byte     = {r_rx, r_mosi_s[1]};
  assign w_boundary = ~w_csn & w_rise & (r_bit == 3'd7);
  // the byte boundary is a rising edge, so the next byte is loaded on the fall right after it
  assign w_load     = ~w_csn & w_fall & (r_bit == 3'd0);
  assign w_dpos     = r_pos - NCR;
  assign w_pre      = r_pos < NCR;
  assign w_is_data  = r_busy & r_data & ~w_pre & (w_dpos > NAC + 16'd1) & (w_dpos < NAC + BLK + 16'd2);
  assign w_next     = (!r_busy || w_pre) ? 8'hFF :
                      !r_data ? r_resp[39:32] :
                      (w_dpos == 16'd0) ? 8'h00 :
                      (w_dpos <= NAC) ? 8'hFF :
                      (w_dpos == NAC + 16'd1) ? 8'hFE :
                      w_is_data ? r_dbyte :
                      (w_dpos == NAC + BLK + 16'd2) ? r_crc[15:8] : r_crc[7:0];

  always_comb begin
    w_acnt_n = r_acnt;
    w_idle_n = r_idle;
    w_app_n  = 1'b0;
    w_rdata  = 1'b0;
    w_len    = 16'd1;
    w_resp   = {5'd0, 1'b1, 1'b0, r_idle, 32'h0};
    if (r_cmd == 6'd0) begin
      w_idle_n = 1'b1;
      w_acnt_n = 8'd0;
      w_resp   = {8'h01, 32'h0};
    end else if (r_cmd == 6'd8) begin
      w_len  = 16'd5;
      w_resp = {7'd0, r_idle, 24'h000001, r_arg};
    end else if (r_cmd == 6'd55) begin
      w_app_n = 1'b1;
      w_resp  = {7'd0, r_idle, 32'h0};
    end else if (r_cmd == 6'd41 && r_app) begin
      w_acnt_n = (r_acnt >= ACNT) ? r_acnt : r_acnt + 8'd1;
      w_idle_n = r_idle & (w_acnt_n < ACNT);
      w_resp   = {7'd0, w_idle_n, 32'h0};
    end else if (r_cmd == 6'd58) begin
      w_len  = 16'd5;
      w_resp = {7'd0, r_idle, r_idle ? 8'h00 : 8'hC0, 24'hFF8000};
    end else if (r_cmd == 6'd17) begin
      w_rdata = ~r_idle;
      w_len   = r_idle ? 16'd1 : NAC + BLK + 16'd4;
      w_resp  = {8'h05, 32'h0};
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      r_bit   <= 3'd0;
      r_rx    <= 7'd0;
      r_tx    <= 8'hFF;
      r_fcnt  <= 3'd0;
      r_cmd   <= 6'd0;
      r_arg   <= 8'd0;
      r_busy  <= 1'b0;
      r_data  <= 1'b0;
      r_idle  <= 1'b1;
      r_app   <= 1'b0;
      r_acnt  <= 8'd0;
      r_resp  <= 40'd0;
      r_pos   <= 16'd0;
      r_total <= 16'd0;
      r_dbyte <= 8'd0;
      r_crc   <= 16'd0;
    end else if (w_csn) begin
      r_bit  <= 3'd0;
      r_tx   <= 8'hFF;
      r_busy <= 1'b0;
      r_fcnt <= 3'd0;
      r_pos  <= 16'd0;
    end else begin
      if (w_rise) begin
        r_rx  <= {r_rx[5:0], r_mosi_s[1]};
        r_bit <= r_bit + 3'd1;
      end
      if (w_fall) r_tx <= w_load ? w_next : {r_tx[6:0], 1'b1};
      if (w_load && r_busy) begin
        r_pos <= r_pos + 16'd1;
        if (!r_data && !w_pre) r_resp <= {r_resp[31:0], 8'hFF};
        if (w_is_data) begin
          r_dbyte <= r_dbyte + 8'd1;
          r_crc   <= crc_step(r_crc, r_dbyte);
        end
      end
      if (w_boundary) begin
        if (r_busy) r_busy <= (r_pos != r_total);
        else if (r_fcnt == 3'd0) begin
          if (w_byte[7:6] == 2'b01) begin
            r_cmd  <= w_byte[5:0];
            r_fcnt <= 3'd1;
          end
        end else if (r_fcnt != 3'd5) begin
          r_arg  <= w_byte;
          r_fcnt <= r_fcnt + 3'd1;
        end else begin
          r_fcnt  <= 3'd0;
          r_busy  <= 1'b1;
          r_pos   <= 16'd0;
          r_total <= NCR + w_len;
          r_resp  <= w_resp;
          r_data  <= w_rdata;
          r_dbyte <= r_arg;
          r_crc   <= 16'd0;
          r_idle  <= w_idle_n;
          r_app   <= w_app_n;
          r_acnt  <= w_acnt_n;
        end
      end
    end

  assign o_miso  = r_tx[7];
  assign o_ready = ~r_idle;
  assign o_busy  = r_busy;
endmodule

// File: tb/tb_sd_hc_spi_responder.sv
// tb_sd_hc_spi_responder: drives SPI host transactions and checks responses against a card-level model.
module tb_sd_hc_spi_responder;
  localparam int BLK  = 512;
  localparam int NCR  = 1;
  localparam int NAC  = 2;
  localparam int ACNT = 2;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic csn = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b1;
  logic miso, ready, busy;
  int checks = 0;
  int failures = 0;
  logic m_idle = 1'b1;
  bit m_app = 1'b0;
  int m_acnt = 0;
  logic [7:0] exp_q[$];

  sd_hc_spi_responder #(.BLOCK_SIZE(BLK), .NCR_BYTES(NCR), .NAC_BYTES(NAC), .ACMD41_COUNT(ACNT)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_csn(csn), .i_sck(sck), .i_mosi(mosi),
    .o_miso(miso), .o_ready(ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    bit app;
    logic [7:0] d;
    logic [15:0] crc;
    app = m_app;
    m_app = 1'b0;
    exp_q.delete();
    repeat (NCR) exp_q.push_back(8'hFF);
    if (idx == 6'd0) begin
      m_idle = 1'b1;
      m_acnt = 0;
      exp_q.push_back(8'h01);
    end else if (idx == 6'd8) begin
      exp_q.push_back({7'd0, m_idle});
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(arg[7:0]);
    end else if (idx == 6'd55) begin
      m_app = 1'b1;
      exp_q.push_back({7'd0, m_idle});
    end else if (idx == 6'd41 && app) begin
      m_acnt++;
      if (m_acnt >= ACNT) m_idle = 1'b0;
      exp_q.push_back({7'd0, m_idle});
    end else if (idx == 6'd58) begin
      exp_q.push_back({7'd0, m_idle});
      exp_q.push_back(m_idle ? 8'h00 : 8'hC0);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h00);
    end else if (idx == 6'd17 && m_idle) begin
      exp_q.push_back(8'h05);
    end else if (idx == 6'd17) begin
      exp_q.push_back(8'h00);
      repeat (NAC) exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      crc = 16'h0000;
      for (int i = 0; i < BLK; i++) begin
        d = 8'(arg[7:0] + i);
        exp_q.push_back(d);
        crc = crc_bits(crc, d);
      end
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
    end else begin
      exp_q.push_back({5'd0, 1'b1, 1'b0, m_idle});
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int limit, input bit rst_abort, input string name);
    logic [7:0] frame [6];
    logic [7:0] rx, got, want;
    int n, m, bad;
    frame[0] = {2'b01, idx};
    frame[1] = arg[31:24];
    frame[2] = arg[23:16];
    frame[3] = arg[15:8];
    frame[4] = arg[7:0];
    frame[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'h01;
    for (int i = 0; i < 6; i++) spi_byte(frame[i], rx);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_frame got=%b exp=1", name, busy);
    end
    model_cmd(idx, arg);
    n = exp_q.size();
    m = (n > limit) ? limit : n;
    bad = -1;
    got = 8'h00;
    want = 8'h00;
    for (int j = 0; j < m; j++) begin
      if (j == n - 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_before_last got=%b exp=1", name, busy);
        end
      end
      spi_byte(8'hFF, rx);
      if (rx !== exp_q[j] && bad < 0) begin
        bad = j;
        got = rx;
        want = exp_q[j];
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s resp byte %0d got=%h exp=%h", name, bad, got, want);
    end
    if (m == n) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_after_last got=%b exp=0", name, busy);
      end
      spi_byte(8'hFF, rx);
      checks++;
      if (rx !== 8'hFF) begin
        failures++;
        $display("FAIL %s trailing got=%h exp=ff", name, rx);
      end
    end else if (!rst_abort) begin
      csn = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (miso !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s cs_abort miso=%b busy=%b exp miso=1 busy=0", name, miso, busy);
      end
      csn = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      @(negedge clk);
      #3 nrst = 1'b0;
      #1;
      checks++;
      if (miso !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s reset_abort miso=%b ready=%b busy=%b exp 1 0 0", name, miso, ready, busy);
      end
      m_idle = 1'b1;
      m_app = 1'b0;
      m_acnt = 0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (4) @(negedge clk);
    end
    checks++;
    if (ready !== ~m_idle) begin
      failures++;
      $display("FAIL %s ready got=%b exp=%b", name, ready, ~m_idle);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (miso !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset miso=%b ready=%b busy=%b exp 1 0 0", miso, ready, busy);
    end
  endtask

  task automatic test_init();
    csn = 1'b0;
    repeat (4) @(negedge clk);
    do_cmd(6'd0, 32'h0, 100, 1'b0, "cmd0");
    do_cmd(6'd8, 32'h000001AA, 100, 1'b0, "cmd8");
    do_cmd(6'd8, $urandom, 100, 1'b0, "cmd8_rand");
    do_cmd(6'd17, $urandom, 100, 1'b0, "cmd17_idle");
    do_cmd(6'd41, 32'h40000000, 100, 1'b0, "cmd41_noapp");
    for (int k = 0; k < ACNT; k++) begin
      do_cmd(6'd55, 32'h0, 100, 1'b0, "cmd55");
      do_cmd(6'd41, 32'h40000000, 100, 1'b0, "acmd41");
    end
    do_cmd(6'd58, 32'h0, 100, 1'b0, "cmd58");
    do_cmd(6'd5, 32'h0, 100, 1'b0, "cmd5");
  endtask

  task automatic test_read();
    do_cmd(6'd17, 32'h3, 100000, 1'b0, "cmd17_addr3");
  endtask

  task automatic test_cs_abort();
    do_cmd(6'd17, $urandom, 20, 1'b0, "cmd17_cs_abort");
    do_cmd(6'd17, 32'h0, 24, 1'b0, "cmd17_addr0");
  endtask

  task automatic test_back_to_back();
    logic [5:0] tbl [7];
    logic [5:0] idx;
    tbl = '{6'd0, 6'd8, 6'd17, 6'd41, 6'd55, 6'd58, 6'd0};
    for (int k = 0; k < 12; k++) begin
      idx = tbl[$urandom_range(0, 6)];
      if (k % 4 == 3) idx = 6'($urandom_range(0, 63));
      do_cmd(idx, $urandom, 16, 1'b0, "b2b");
    end
  endtask

  task automatic test_reset_abort();
    do_cmd(6'd0, 32'h0, 100, 1'b0, "cmd0_pre");
    for (int k = 0; k < ACNT; k++) begin
      do_cmd(6'd55, 32'h0, 100, 1'b0, "cmd55_pre");
      do_cmd(6'd41, 32'h40000000, 100, 1'b0, "acmd41_pre");
    end
    do_cmd(6'd17, $urandom, 30, 1'b1, "cmd17_reset");
    do_cmd(6'd58, 32'h0, 100, 1'b0, "cmd58_after_reset");
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_cs_abort();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
